regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port (rd address/data, 32 x WORDSIZE) between two write-back requesters using valid/ready handshakes and round-robin priority.
- After reset, or on request, runs a clear sequence that writes zero to x1..x(SIZE-1) before accepting traffic.
- Sits between the execute/load units and the register file inside the processor.

---
 rtl/rf_pkg.sv | 16 +
 rtl/regfile_wr_arbiter_rr_arb2.sv | 46 ++++
 rtl/regfile_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_pkg;

    localparam int WORDSIZE_DEF = 64;
    localparam int SIZE_DEF     = 32;
    localparam int ADDR_W       = $clog2(SIZE_DEF);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer moves to the other requester after any grant.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[REQ0] && req[REQ1]) begin
                gnt[ptr_q] = 1'b1;
            end else if (req[REQ0]) begin
                gnt[REQ0] = 1'b1;
            end else if (req[REQ1]) begin
                gnt[REQ1] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[REQ0]) begin
            ptr_d = REQ1;
        end else if (gnt[REQ1]) begin
            ptr_d = REQ0;
        end
    end

    // NOTE: state flops use non-blocking assignment; reset is synchronous, sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a zero-fill clear sequence.
// Optional pending-write scoreboard enabled by defining RF_ARB_SCOREBOARD_EN.
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int SIZE     = SIZE_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [$clog2(SIZE)-1:0]   req0_addr,
    input  logic [WORDSIZE-1:0]       req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [$clog2(SIZE)-1:0]   req1_addr,
    input  logic [WORDSIZE-1:0]       req1_data,
    input  logic                      wr_stall,
    input  logic                      clear_req,
    output logic                      wr_en,
    output logic [$clog2(SIZE)-1:0]   wr_addr,
    output logic [WORDSIZE-1:0]       wr_data,
    output logic                      busy,
    output logic                      clear_done
`ifdef RF_ARB_SCOREBOARD_EN
    ,
    input  logic                      rsv_valid,
    input  logic [$clog2(SIZE)-1:0]   rsv_addr,
    output logic [SIZE-1:0]           pending
`endif
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(SIZE - 1);

    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_RUN   = RUN;

    logic [0:0]          state_q,      state_d;
    logic [AW-1:0]       clr_ptr_q,    clr_ptr_d;
    logic                wr_en_q,      wr_en_d;
    logic [AW-1:0]       wr_addr_q,    wr_addr_d;
    logic [WORDSIZE-1:0] wr_data_q,    wr_data_d;
    logic                clear_done_q, clear_done_d;

    logic                arb_en;
    logic [1:0]          gnt;
    logic [AW-1:0]       sel_addr;
    logic [WORDSIZE-1:0] sel_data;

    // Grants are withheld while reset is asserted so no requester sees a dropped accept.
    assign arb_en = !rst && (state_q == ST_RUN) && !wr_stall && !clear_req;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[REQ0];
    assign req1_ready = gnt[REQ1];
    assign sel_addr   = gnt[REQ1] ? req1_addr : req0_addr;
    assign sel_data   = gnt[REQ1] ? req1_data : req0_data;

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        clear_done_d = 1'b0;

        if (state_q == ST_CLEAR) begin
            if (!wr_stall) begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_ptr_q;
                wr_data_d = '0;
                if (clr_ptr_q == LAST_ADDR) begin
                    clear_done_d = 1'b1;
                    state_d      = ST_RUN;
                    clr_ptr_d    = FIRST_ADDR;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
        end else begin
            if (clear_req) begin
                state_d   = ST_CLEAR;
                clr_ptr_d = FIRST_ADDR;
            end else if (gnt != 2'b00) begin
                // x0 writes are accepted and consume the turn, but never reach the file.
                if (sel_addr != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= FIRST_ADDR;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign clear_done = clear_done_q;
    assign busy       = (state_q == ST_CLEAR);

`ifdef RF_ARB_SCOREBOARD_EN
    logic [SIZE-1:0] pending_q, pending_d;

    // The write issuing at this edge clears its bit first so a same-edge reservation wins.
    always_comb begin
        pending_d = pending_q;
        if ((state_q == ST_RUN) && (state_d == ST_CLEAR)) begin
            pending_d = '0;
        end else begin
            if (wr_en_d) begin
                pending_d[wr_addr_d] = 1'b0;
            end
            if (rsv_valid && (rsv_addr != '0)) begin
                pending_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wr_arbiter;

    localparam int WS = 64;
    localparam int SZ = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [4:0]    req0_addr;
    logic [WS-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [4:0]    req1_addr;
    logic [WS-1:0] req1_data;
    logic          wr_stall, clear_req;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [WS-1:0] wr_data;
    logic          busy, clear_done;
`ifdef RF_ARB_SCOREBOARD_EN
    logic          rsv_valid;
    logic [4:0]    rsv_addr;
    logic [SZ-1:0] pending;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: whose turn it is on a tie, and the expected registered write port.
    int            m_fav;
    logic          m_en;
    logic [4:0]    m_addr;
    logic [WS-1:0] m_data;

    regfile_wr_arbiter #(.WORDSIZE(WS), .SIZE(SZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wr_stall   (wr_stall),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .clear_done (clear_done)
`ifdef RF_ARB_SCOREBOARD_EN
        ,
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .pending    (pending)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one RUN cycle and predicts the grant and next write from the arbitration rules.
    task automatic drive_cycle(input logic v0, input logic [4:0] a0, input logic [WS-1:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [WS-1:0] d1,
                               input logic st, input logic cr,
                               output logic e0, output logic e1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        wr_stall   = st; clear_req = cr;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!st && !cr) begin
            if (v0 && v1) begin
                e0 = (m_fav == 0);
                e1 = (m_fav == 1);
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        m_en = 1'b0;
        if (e0) begin
            m_fav = 1;
            if (a0 != 5'd0) begin m_en = 1'b1; m_addr = a0; m_data = d0; end
        end else if (e1) begin
            m_fav = 0;
            if (a1 != 5'd0) begin m_en = 1'b1; m_addr = a1; m_data = d1; end
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd2; req0_data = '1;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = '0;
        wr_stall = 1'b0; clear_req = 1'b0;
`ifdef RF_ARB_SCOREBOARD_EN
        rsv_valid = 1'b0; rsv_addr = 5'd0;
`endif
        tick;
        tick;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== '0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: wr_en=%0b addr=%0d data=%h done=%0b, need 0 0 0 0",
                     wr_en, wr_addr, wr_data, clear_done);
        end
        checks++;
        if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%0b ready=%0b%0b, need busy=1 ready=00",
                     busy, req0_ready, req1_ready);
        end
`ifdef RF_ARB_SCOREBOARD_EN
        checks++;
        if (pending !== '0) begin
            errors++;
            $display("FAIL reset_pending: got %h need 0", pending);
        end
`endif
        m_fav = 0; m_en = 1'b0; m_addr = 5'd0; m_data = '0;
    endtask

    // Expects an unstalled clear already under way: x1..x31 zeroed, one per cycle.
    task automatic test_clear_sequence(input string tag);
        rst = 1'b0;
        wr_stall = 1'b0;
        clear_req = 1'b0;
        for (int i = 1; i < SZ; i++) begin
            logic ok;
            tick;
            ok = (wr_en === 1'b1) && (wr_addr === 5'(i)) && (wr_data === '0) &&
                 (clear_done === (i == SZ - 1)) && (busy === (i != SZ - 1));
            if (i != SZ - 1) ok = ok && (req0_ready === 1'b0) && (req1_ready === 1'b0);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s[%0d]: wr_en=%0b addr=%0d data=%h done=%0b busy=%0b ready=%0b%0b, need 1 %0d 0 %0b %0b 00",
                         tag, i, wr_en, wr_addr, wr_data, clear_done, busy, req0_ready, req1_ready,
                         i, (i == SZ - 1), (i != SZ - 1));
            end
        end
        m_en = 1'b0; m_addr = 5'(SZ - 1); m_data = '0;
    endtask

    task automatic test_back_to_back;
        logic e0, e1;
        logic [WS-1:0] d0, d1;
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 5'd5, d0, 1'b1, 5'd6, d1, 1'b0, 1'b0, e0, e1);
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL alternate_grant[%0d]: ready=%0b%0b need %0b%0b",
                         i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            tick;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== ((i % 2 == 0) ? 5'd5 : 5'd6) ||
                wr_data !== ((i % 2 == 0) ? d0 : d1)) begin
                errors++;
                $display("FAIL alternate_write[%0d]: wr_en=%0b addr=%0d data=%h",
                         i, wr_en, wr_addr, wr_data);
            end
        end
    endtask

    task automatic test_single_req0;
        logic e0, e1;
        drive_cycle(1'b1, 5'd4, 64'h0000_0000_5F11_E01A, 1'b0, 5'd9, '0, 1'b0, 1'b0, e0, e1);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: ready=%0b%0b need 10", req0_ready, req1_ready);
        end
        tick;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 64'h0000_0000_5F11_E01A) begin
            errors++;
            $display("FAIL single_write: wr_en=%0b addr=%0d data=%h need 1 4 000000005f11e01a",
                     wr_en, wr_addr, wr_data);
        end
        drive_cycle(1'b0, 5'd4, '0, 1'b0, 5'd9, '0, 1'b0, 1'b0, e0, e1);
        tick;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd4 || wr_data !== 64'h0000_0000_5F11_E01A) begin
            errors++;
            $display("FAIL idle_hold: wr_en=%0b addr=%0d data=%h need 0 4 000000005f11e01a",
                     wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_stall;
        logic e0, e1;
        logic [WS-1:0] d0, d1;
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 5'd9, d0, 1'b1, 5'd10, d1, 1'b1, 1'b0, e0, e1);
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: ready=%0b%0b need 00", i, req0_ready, req1_ready);
            end
            tick;
            checks++;
            if (wr_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_wr_en[%0d]: got %0b need 0", i, wr_en);
            end
        end
        // requester 0 was served last, so the turn belongs to requester 1
        drive_cycle(1'b1, 5'd9, d0, 1'b1, 5'd10, d1, 1'b0, 1'b0, e0, e1);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_grant: ready=%0b%0b need 01", req0_ready, req1_ready);
        end
        tick;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd10 || wr_data !== d1) begin
            errors++;
            $display("FAIL stall_release_write: wr_en=%0b addr=%0d data=%h need 1 10 %h",
                     wr_en, wr_addr, wr_data, d1);
        end
    endtask

    task automatic test_x0;
        logic e0, e1;
        logic [WS-1:0] d0;
        d0 = {$urandom, $urandom};
        drive_cycle(1'b1, 5'd3, d0, 1'b0, 5'd0, '0, 1'b0, 1'b0, e0, e1);
        tick;
        drive_cycle(1'b0, 5'd3, d0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, e0, e1);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_ready: ready=%0b%0b need 01", req0_ready, req1_ready);
        end
        tick;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd3 || wr_data !== d0) begin
            errors++;
            $display("FAIL x0_no_write: wr_en=%0b addr=%0d data=%h need 0 3 %h",
                     wr_en, wr_addr, wr_data, d0);
        end
        drive_cycle(1'b1, 5'd11, d0, 1'b1, 5'd12, '1, 1'b0, 1'b0, e0, e1);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_rr_advance: ready=%0b%0b need 10", req0_ready, req1_ready);
        end
        tick;
        drive_cycle(1'b0, 5'd11, d0, 1'b1, 5'd12, '1, 1'b0, 1'b0, e0, e1);
        tick;
    endtask

    task automatic test_random;
        logic e0, e1, st;
        logic r0v, r1v;
        logic [4:0] r0a, r1a;
        logic [WS-1:0] r0d, r1d;
        r0v = 1'b1; r0a = 5'($urandom_range(0, 31)); r0d = {$urandom, $urandom};
        r1v = 1'b1; r1a = 5'($urandom_range(0, 31)); r1d = {$urandom, $urandom};
        for (int c = 0; c < 300; c++) begin
            st = ($urandom_range(0, 3) == 0);
            drive_cycle(r0v, r0a, r0d, r1v, r1a, r1d, st, 1'b0, e0, e1);
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++;
                $display("FAIL random_ready[%0d]: ready=%0b%0b need %0b%0b",
                         c, req0_ready, req1_ready, e0, e1);
            end
            tick;
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {m_en, m_addr, m_data}) begin
                errors++;
                $display("FAIL random_write[%0d]: wr_en=%0b addr=%0d data=%h need %0b %0d %h",
                         c, wr_en, wr_addr, wr_data, m_en, m_addr, m_data);
            end
            if (e0 || !r0v) begin
                r0v = (e0 ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) != 0));
                r0a = 5'($urandom_range(0, 31));
                r0d = {$urandom, $urandom};
            end
            if (e1 || !r1v) begin
                r1v = (e1 ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) != 0));
                r1a = 5'($urandom_range(0, 31));
                r1d = {$urandom, $urandom};
            end
        end
    endtask

    task automatic test_clear_req;
        logic e0, e1;
        logic [WS-1:0] d0;
        d0 = {$urandom, $urandom};
`ifdef RF_ARB_SCOREBOARD_EN
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        drive_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 1'b0, e0, e1);
        tick;
        rsv_valid = 1'b0;
        checks++;
        if (pending !== 32'h0000_0080) begin
            errors++;
            $display("FAIL pending_set: got %h need 00000080", pending);
        end
`endif
        drive_cycle(1'b1, 5'd13, d0, 1'b0, 5'd0, '0, 1'b0, 1'b1, e0, e1);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_req_ready: ready=%0b%0b need 00", req0_ready, req1_ready);
        end
        tick;
        clear_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_req_entry: busy=%0b wr_en=%0b need 1 0", busy, wr_en);
        end
`ifdef RF_ARB_SCOREBOARD_EN
        checks++;
        if (pending !== '0) begin
            errors++;
            $display("FAIL pending_clear: got %h need 0", pending);
        end
`endif
        wr_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (wr_en !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_stall[%0d]: wr_en=%0b busy=%0b ready0=%0b need 0 1 0",
                         i, wr_en, busy, req0_ready);
            end
        end
        wr_stall = 1'b0;
        test_clear_sequence("clear_restart");
        drive_cycle(1'b1, 5'd13, d0, 1'b0, 5'd0, '0, 1'b0, 1'b0, e0, e1);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_clear_grant: ready0=%0b need 1", req0_ready);
        end
        tick;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd13 || wr_data !== d0) begin
            errors++;
            $display("FAIL post_clear_write: wr_en=%0b addr=%0d data=%h need 1 13 %h",
                     wr_en, wr_addr, wr_data, d0);
        end
    endtask

    task automatic test_reset_midrun;
        logic e0, e1;
        drive_cycle(1'b1, 5'd20, {$urandom, $urandom}, 1'b0, 5'd0, '0, 1'b0, 1'b0, e0, e1);
        tick;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd20) begin
            errors++;
            $display("FAIL midrun_write: wr_en=%0b addr=%0d need 1 20", wr_en, wr_addr);
        end
        rst = 1'b1;
        req0_valid = 1'b0;
        tick;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset: wr_en=%0b addr=%0d busy=%0b need 0 0 1", wr_en, wr_addr, busy);
        end
        test_clear_sequence("clear_after_reset");
    endtask

    initial begin
        test_reset;
        test_clear_sequence("clear_initial");
        test_back_to_back;
        test_single_req0;
        test_stall;
        test_x0;
        test_random;
        test_clear_req;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
